// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus arbiter.
// Contents:
//   arb_state_e  - arbiter FSM state encoding
//   BUS_IDLE_LVL - resting level of the serial master lines
//   BUS_ACK_LVL  - level driven on a master RX line to acknowledge a grant
package bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StAddr,
    StWaitSlv,
    StBusy
  } arb_state_e;

  localparam logic BUS_IDLE_LVL = 1'b1;
  localparam logic BUS_ACK_LVL  = 1'b0;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   i_req   - request vector, one bit per master
//   i_last  - index of the most recently granted master
//   o_gnt   - one-hot winner (all zeros when no request)
//   o_idx   - index of the winner
//   o_valid - at least one request present
// Search starts at i_last+1 and wraps modulo N_MST.
module rr_picker #(
  parameter int unsigned N_MST = 4,
  localparam int unsigned IW = $clog2(N_MST)
) (
  input  logic [N_MST-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [N_MST-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_valid
);

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    found = 1'b0;
    j     = '0;
    o_gnt = '0;
    o_idx = '0;
    for (int unsigned k = 1; k <= N_MST; k++) begin
      j = IW'((32'(i_last) + k) % N_MST);
      if (!found && i_req[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j;
      end
    end
    o_valid = found;
  end

endmodule

// File: rtl/serial_bus_arbiter_rr.sv
// Round-robin arbiter for the serial bus.
// Grants one master at a time, deserialises its slave address (MSB first),
// presents it to the decoder and holds the grant until the slave responds.
// A slave that does not become ready within TIMEOUT cycles is aborted.
// Ports:
//   i_clk, i_rstn     - clock, asynchronous active-low reset
//   i_mst_tx          - master TX lines (idle 1, low in IDLE = request)
//   o_mst_rx          - master RX lines (idle 1, one-cycle low = grant ack)
//   i_slv_ready       - addressed slave accepted the transaction
//   i_slv_responded   - transaction complete
//   o_grant           - one-hot bus owner, zero when free
//   o_addr            - captured slave address
//   o_addr_rdy        - one-cycle strobe, o_addr valid
//   o_abort           - one-cycle strobe, slave timeout
module serial_bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int unsigned N_MST   = 4,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [N_MST-1:0]  i_mst_tx,
  output logic [N_MST-1:0]  o_mst_rx,
  input  logic              i_slv_ready,
  input  logic              i_slv_responded,
  output logic [N_MST-1:0]  o_grant,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_addr_rdy,
  output logic              o_abort
);

  localparam int unsigned IW = $clog2(N_MST);
  localparam int unsigned BW = $clog2(ADDR_W + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  arb_state_e        r_state,     w_state_next;
  logic [N_MST-1:0]  r_grant,     w_grant_next;
  logic [IW-1:0]     r_gidx,      w_gidx_next;
  logic [IW-1:0]     r_last,      w_last_next;
  logic [ADDR_W-1:0] r_shift,     w_shift_next;
  logic [ADDR_W-1:0] r_addr,      w_addr_next;
  logic              r_addr_rdy,  w_addr_rdy_next;
  logic              r_abort,     w_abort_next;
  logic [BW-1:0]     r_bit_cnt,   w_bit_cnt_next;
  logic [TW-1:0]     r_tmo_cnt,   w_tmo_cnt_next;

  logic [N_MST-1:0]  w_req;
  logic [N_MST-1:0]  w_pick_gnt;
  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_valid;
  logic              w_tx_bit;
  logic [ADDR_W-1:0] w_shift_in;

  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      w_req[i] = (i_mst_tx[i] != BUS_IDLE_LVL);
    end
  end

  rr_picker #(
    .N_MST (N_MST)
  ) u_picker (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // Only the granted master's TX line feeds the shifter.
  assign w_tx_bit   = |(i_mst_tx & r_grant);
  assign w_shift_in = (r_shift << 1) | ADDR_W'(w_tx_bit);

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_gidx_next     = r_gidx;
    w_last_next     = r_last;
    w_shift_next    = r_shift;
    w_addr_next     = r_addr;
    w_addr_rdy_next = 1'b0;
    w_abort_next    = 1'b0;
    w_bit_cnt_next  = r_bit_cnt;
    w_tmo_cnt_next  = r_tmo_cnt;

    case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_grant_next = w_pick_gnt;
          w_gidx_next  = w_pick_idx;
          w_state_next = StAck;
        end
      end
      StAck: begin
        w_last_next    = r_gidx;
        w_bit_cnt_next = '0;
        w_state_next   = StAddr;
      end
      StAddr: begin
        w_shift_next = w_shift_in;
        if (r_bit_cnt == BW'(ADDR_W - 1)) begin
          w_addr_next     = w_shift_in;
          w_addr_rdy_next = 1'b1;
          w_tmo_cnt_next  = '0;
          w_state_next    = StWaitSlv;
        end else begin
          w_bit_cnt_next = r_bit_cnt + BW'(1);
        end
      end
      StWaitSlv: begin
        w_tmo_cnt_next = r_tmo_cnt + TW'(1);
        // Ready wins over the terminal count.
        if (i_slv_ready) begin
          if (i_slv_responded) begin
            w_grant_next = '0;
            w_state_next = StIdle;
          end else begin
            w_state_next = StBusy;
          end
        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          w_abort_next = 1'b1;
          w_grant_next = '0;
          w_state_next = StIdle;
        end
      end
      StBusy: begin
        if (i_slv_responded) begin
          w_grant_next = '0;
          w_state_next = StIdle;
        end
      end
      default: begin
        w_grant_next = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_last     <= IW'(N_MST - 1);
      r_shift    <= '0;
      r_addr     <= '0;
      r_addr_rdy <= 1'b0;
      r_abort    <= 1'b0;
      r_bit_cnt  <= '0;
      r_tmo_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_gidx     <= w_gidx_next;
      r_last     <= w_last_next;
      r_shift    <= w_shift_next;
      r_addr     <= w_addr_next;
      r_addr_rdy <= w_addr_rdy_next;
      r_abort    <= w_abort_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_tmo_cnt  <= w_tmo_cnt_next;
    end
  end

  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      o_mst_rx[i] = (r_state == StAck && r_grant[i]) ? BUS_ACK_LVL : BUS_IDLE_LVL;
    end
  end

  assign o_grant    = r_grant;
  assign o_addr     = r_addr;
  assign o_addr_rdy = r_addr_rdy;
  assign o_abort    = r_abort;

endmodule

// File: tb/tb_serial_bus_arbiter_rr.sv
module tb_serial_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] mst_tx;
  logic [3:0] mst_rx;
  logic       slv_ready;
  logic       slv_responded;
  logic [3:0] grant;
  logic [3:0] addr;
  logic       addr_rdy;
  logic       abort;

  int n_cmp = 0;
  int n_err = 0;

  serial_bus_arbiter_rr #(
    .N_MST   (4),
    .ADDR_W  (4),
    .TIMEOUT (8)
  ) dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_mst_tx        (mst_tx),
    .o_mst_rx        (mst_rx),
    .i_slv_ready     (slv_ready),
    .i_slv_responded (slv_responded),
    .o_grant         (grant),
    .o_addr          (addr),
    .o_addr_rdy      (addr_rdy),
    .o_abort         (abort)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    mst_tx = 4'hF;
    slv_ready = 1'b0;
    slv_responded = 1'b0;
    step;
    step;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    slv_ready = 1'b0;
    slv_responded = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mst_tx = 4'($urandom);
      step;
      n_cmp++;
      if (mst_rx !== 4'hF || grant !== 4'h0 || addr !== 4'h0 || addr_rdy !== 1'b0 ||
          abort !== 1'b0) begin
        n_err++;
        $display("FAIL reset_%0d: rx=%b grant=%b addr=%h rdy=%b abort=%b, want rx=1111 0 0 0 0",
                 i, mst_rx, grant, addr, addr_rdy, abort);
      end
    end
    mst_tx = 4'hF;
    step;
    rstn = 1'b1;
  endtask

  task automatic test_single;
    logic [3:0] bits;
    bits = 4'hA;
    mst_tx = 4'b1011;            // cycle t
    step;                        // t+1
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_err++; $display("FAIL single_grant: got %b want 0100", grant);
    end
    n_cmp++;
    if (mst_rx !== 4'b1011) begin
      n_err++; $display("FAIL single_ack: got %b want 1011", mst_rx);
    end
    mst_tx = 4'hF;
    step;                        // t+2
    for (int i = 3; i >= 0; i--) begin
      mst_tx[2] = bits[i];
      step;
    end                          // t+6
    mst_tx = 4'hF;
    n_cmp++;
    if (addr_rdy !== 1'b1 || addr !== 4'hA) begin
      n_err++; $display("FAIL single_addr: rdy=%b addr=%h want rdy=1 addr=a", addr_rdy, addr);
    end
    n_cmp++;
    if (mst_rx !== 4'hF) begin
      n_err++; $display("FAIL single_rx_idle: got %b want 1111", mst_rx);
    end
    step;                        // t+7
    n_cmp++;
    if (addr_rdy !== 1'b0) begin
      n_err++; $display("FAIL single_rdy_pulse: got %b want 0", addr_rdy);
    end
    step;                        // t+8
    slv_ready = 1'b1;
    step;                        // t+9
    slv_ready = 1'b0;
    step;                        // t+10
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_err++; $display("FAIL single_busy_hold: got %b want 0100", grant);
    end
    slv_responded = 1'b1;
    step;                        // t+11
    slv_responded = 1'b0;
    n_cmp++;
    if (grant !== 4'b0000) begin
      n_err++; $display("FAIL single_release: got %b want 0000", grant);
    end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset;
    mst_tx = 4'h0;
    slv_ready = 1'b1;
    slv_responded = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 20 && grant === 4'h0; c++) step;
      n_cmp++;
      if (grant !== exp_order[k]) begin
        n_err++; $display("FAIL fair_%0d: got %b want %b", k, grant, exp_order[k]);
      end
      for (int c = 0; c < 20 && grant !== 4'h0; c++) step;
    end
    mst_tx = 4'hF;
    slv_ready = 1'b0;
    slv_responded = 1'b0;
    step;
  endtask

  task automatic test_timeout;
    do_reset;
    mst_tx = 4'b1110;            // t: master 0
    step;                        // t+1
    mst_tx = 4'b0111;            // master 0 sends ones, master 3 pending
    for (int i = 0; i < 5; i++) step;   // t+6
    n_cmp++;
    if (addr_rdy !== 1'b1 || addr !== 4'hF) begin
      n_err++; $display("FAIL tmo_addr: rdy=%b addr=%h want rdy=1 addr=f", addr_rdy, addr);
    end
    for (int i = 0; i < 7; i++) step;   // t+13: 8th WAIT_SLV cycle
    n_cmp++;
    if (abort !== 1'b0 || grant !== 4'b0001) begin
      n_err++; $display("FAIL tmo_early: abort=%b grant=%b want 0 0001", abort, grant);
    end
    step;                        // t+14
    n_cmp++;
    if (abort !== 1'b1 || grant !== 4'b0000) begin
      n_err++; $display("FAIL tmo_abort: abort=%b grant=%b want 1 0000", abort, grant);
    end
    step;                        // t+15
    n_cmp++;
    if (abort !== 1'b0 || grant !== 4'b1000 || mst_rx !== 4'b0111) begin
      n_err++; $display("FAIL tmo_next: abort=%b grant=%b rx=%b want 0 1000 0111",
                        abort, grant, mst_rx);
    end
    mst_tx = 4'hF;
  endtask

  task automatic test_tie;
    do_reset;
    mst_tx = 4'b1101;            // t: master 1
    step;                        // t+1
    mst_tx = 4'hF;
    for (int i = 0; i < 12; i++) step;  // t+13: terminal count cycle
    slv_ready = 1'b1;
    step;                        // t+14
    slv_ready = 1'b0;
    n_cmp++;
    if (abort !== 1'b0 || grant !== 4'b0010) begin
      n_err++; $display("FAIL tie_busy: abort=%b grant=%b want 0 0010", abort, grant);
    end
    for (int i = 0; i < 10; i++) step;  // BUSY has no timeout
    n_cmp++;
    if (abort !== 1'b0 || grant !== 4'b0010) begin
      n_err++; $display("FAIL tie_hold: abort=%b grant=%b want 0 0010", abort, grant);
    end
    slv_responded = 1'b1;
    step;
    slv_responded = 1'b0;
    n_cmp++;
    if (grant !== 4'b0000) begin
      n_err++; $display("FAIL tie_release: got %b want 0000", grant);
    end
  endtask

  task automatic test_reset_mid;
    // addr still holds f from the previous transaction
    mst_tx = 4'b1101;            // t: master 1
    step;                        // t+1
    n_cmp++;
    if (grant !== 4'b0010) begin
      n_err++; $display("FAIL mid_grant: got %b want 0010", grant);
    end
    mst_tx = 4'hF;
    step;                        // t+2 ADDR
    step;                        // t+3 ADDR
    rstn = 1'b0;
    #2;
    n_cmp++;
    if (mst_rx !== 4'hF || grant !== 4'h0 || addr !== 4'h0 || addr_rdy !== 1'b0 ||
        abort !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: rx=%b grant=%b addr=%h rdy=%b abort=%b, want 1111 0 0 0 0",
               mst_rx, grant, addr, addr_rdy, abort);
    end
    rstn = 1'b1;
    mst_tx = 4'b1100;            // masters 0 and 1
    step;
    mst_tx = 4'hF;
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_err++; $display("FAIL mid_regrant: got %b want 0001", grant);
    end
  endtask

  initial begin
    rstn = 1'b0;
    mst_tx = 4'hF;
    slv_ready = 1'b0;
    slv_responded = 1'b0;
    test_reset;
    test_single;
    test_fairness;
    test_timeout;
    test_tie;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
